// File: rtl/lin_to_log_tap_loader.sv
// Linear-to-log encoder feeding an ORD-tap delay line of {log, sign, nonzero} fields.
// Latency 2: stage 1 registers |x|/sign/zero, stage 2 encodes and shifts into tap 0.
// Backpressure: whole pipeline stalls while out_valid=1 and out_ready=0; in_ready=!stall.
//
// Ports:
//   clk, reset (async active-low), clear (sync flush)
//   in_data/in_valid/in_ready          : linear sample handshake
//   log_out_packed/sign_out_packed/valid_out_packed : tap k at [LOG_WIDTH*k +: LOG_WIDTH] / [k]
//   out_valid/out_ready                : "delay line updated" handshake
// Optional macro LOG_ENC_CORR_EN: adds Mitchell fraction correction (no added latency).
module lin_to_log_tap_loader #(
    parameter int WIDTH     = 16,
    parameter int QP        = 12,
    parameter int ORD       = 64,
    parameter int LOG_WIDTH = 17,
    parameter int LOG_FRAC  = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [ORD*LOG_WIDTH-1:0] log_out_packed,
    output logic [ORD-1:0]           sign_out_packed,
    output logic [ORD-1:0]           valid_out_packed,
    output logic                     out_valid,
    input  logic                     out_ready
);

    // Stage 1 registers
    logic             s1_vld_q,  s1_vld_d;
    logic [WIDTH-1:0] s1_mag_q,  s1_mag_d;
    logic             s1_neg_q,  s1_neg_d;
    logic             s1_zero_q, s1_zero_d;

    // Delay line and update flag
    logic [ORD*LOG_WIDTH-1:0] log_q,  log_d;
    logic [ORD-1:0]           sign_q, sign_d;
    logic [ORD-1:0]           nz_q,   nz_d;
    logic                     out_valid_q, out_valid_d;

    logic             stall;
    logic             fire;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;

    // Encoder intermediates
    int                          lead;
    int                          log_int;
    logic [WIDTH+LOG_FRAC-1:0]   rem_w;
    logic [LOG_FRAC-1:0]         frac_raw;
    logic [LOG_FRAC-1:0]         frac;
    logic [LOG_WIDTH-1:0]        enc_log;
`ifdef LOG_ENC_CORR_EN
    logic [LOG_FRAC:0]           one_minus;
    logic [LOG_FRAC:0]           corr_sum;
`endif

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign fire     = s1_vld_q & ~stall;

    // Two's-complement negate in WIDTH bits: the most-negative value maps to
    // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit magnitude.
    assign in_neg = in_data[WIDTH-1];
    assign in_mag = in_neg ? (~in_data + WIDTH'(1)) : in_data;

    // Mitchell log2 of the stage-1 magnitude
    always_comb begin
        lead = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_mag_q[i]) lead = i;
        end
        // Bits below the leading one, aligned so the fraction is always the
        // top LOG_FRAC of them (zero-filled when fewer than LOG_FRAC exist).
        rem_w = (WIDTH+LOG_FRAC)'(s1_mag_q) & ~((WIDTH+LOG_FRAC)'(1) << lead);
        if (lead >= LOG_FRAC) begin
            frac_raw = LOG_FRAC'(rem_w >> (lead - LOG_FRAC));
        end else begin
            frac_raw = LOG_FRAC'(rem_w << (LOG_FRAC - lead));
        end
`ifdef LOG_ENC_CORR_EN
        one_minus = {1'b1, {LOG_FRAC{1'b0}}} - {1'b0, frac_raw};
        if (!frac_raw[LOG_FRAC-1]) begin
            corr_sum = {1'b0, frac_raw} + {3'b000, frac_raw[LOG_FRAC-1:2]};
        end else begin
            corr_sum = {1'b0, frac_raw} + (one_minus >> 2);
        end
        frac = corr_sum[LOG_FRAC] ? '1 : corr_sum[LOG_FRAC-1:0];
`else
        frac = frac_raw;
`endif
        log_int = (lead - QP) * (2 ** LOG_FRAC) + int'(frac);
        enc_log = s1_zero_q ? '0 : LOG_WIDTH'(log_int);
    end

    // Next-state logic
    always_comb begin
        s1_vld_d    = s1_vld_q;
        s1_mag_d    = s1_mag_q;
        s1_neg_d    = s1_neg_q;
        s1_zero_d   = s1_zero_q;
        log_d       = log_q;
        sign_d      = sign_q;
        nz_d        = nz_q;
        out_valid_d = out_valid_q;

        if (!stall) begin
            s1_vld_d  = in_valid;
            s1_mag_d  = in_mag;
            s1_neg_d  = in_neg;
            s1_zero_d = (in_data == '0);
        end

        if (fire) begin
            log_d  = {log_q[(ORD-1)*LOG_WIDTH-1:0], enc_log};
            sign_d = {sign_q[ORD-2:0], s1_neg_q};
            nz_d   = {nz_q[ORD-2:0], ~s1_zero_q};
        end

        // A new shift keeps the flag up even if the consumer just took the last one
        if (fire) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Flush wins over any accept or shift in the same cycle
        if (clear) begin
            s1_vld_d    = 1'b0;
            s1_mag_d    = '0;
            s1_neg_d    = 1'b0;
            s1_zero_d   = 1'b0;
            log_d       = '0;
            sign_d      = '0;
            nz_d        = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= 1'b0;
            s1_mag_q    <= '0;
            s1_neg_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
            log_q       <= '0;
            sign_q      <= '0;
            nz_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_mag_q    <= s1_mag_d;
            s1_neg_q    <= s1_neg_d;
            s1_zero_q   <= s1_zero_d;
            log_q       <= log_d;
            sign_q      <= sign_d;
            nz_q        <= nz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign log_out_packed   = log_q;
    assign sign_out_packed  = sign_q;
    assign valid_out_packed = nz_q;
    assign out_valid        = out_valid_q;

endmodule

// File: tb/tb_lin_to_log_tap_loader.sv
module tb_lin_to_log_tap_loader;

    localparam int WIDTH = 16;
    localparam int QP    = 12;
    localparam int ORD   = 64;
    localparam int LW    = 17;
    localparam int LF    = 12;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                clear = 1'b0;
    logic [WIDTH-1:0]    in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [ORD*LW-1:0]   log_out_packed;
    logic [ORD-1:0]      sign_out_packed;
    logic [ORD-1:0]      valid_out_packed;
    logic                out_valid;
    logic                out_ready = 1'b1;

    lin_to_log_tap_loader #(
        .WIDTH(WIDTH), .QP(QP), .ORD(ORD), .LOG_WIDTH(LW), .LOG_FRAC(LF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .log_out_packed(log_out_packed),
        .sign_out_packed(sign_out_packed),
        .valid_out_packed(valid_out_packed),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries: {log, sign, nonzero}
    logic [LW+1:0] sb_q[$];

    typedef struct {
        int din;
        int exp_log;
        bit exp_sign;
        bit exp_vld;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference encoder: log2 via integer p plus fraction (rem * 2^LF) / 2^p
    function automatic logic [LW+1:0] enc(input int x);
        int m, p, rem, frac, lg;
        logic [LW-1:0] l;
        if (x == 0) return '0;
        m = (x < 0) ? -x : x;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        rem  = m - (1 << p);
        frac = (rem * (1 << LF)) >> p;
`ifdef LOG_ENC_CORR_EN
        if (frac < (1 << (LF - 1))) frac = frac + frac / 4;
        else                        frac = frac + ((1 << LF) - frac) / 4;
        if (frac > (1 << LF) - 1)   frac = (1 << LF) - 1;
`endif
        lg = (p - QP) * (1 << LF) + frac;
        l  = lg[LW-1:0];
        return {l, (x < 0), 1'b1};
    endfunction

    // Monitor: push on accept, pop/compare tap 0 on each update handshake
    always @(negedge clk) begin
        logic [LW+1:0] e;
        logic [LW-1:0] a_log;
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected_update: got update with %0d pending, expected none", sb_q.size());
                end else begin
                    e     = sb_q.pop_front();
                    a_log = log_out_packed[LW-1:0];
                    chk("sb_tap0_log",  a_log,               e[LW+1:2]);
                    chk("sb_tap0_sign", sign_out_packed[0],  e[1]);
                    chk("sb_tap0_vld",  valid_out_packed[0], e[0]);
                end
            end
            if (in_valid && in_ready && !clear) sb_q.push_back(enc($signed(in_data)));
        end
    end

    // Offer one sample from posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [WIDTH-1:0] d);
        int t;
        in_data  = d;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: in_ready got 0 after %0d cycles, expected 1", t);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [ORD*LW-1:0] snap;
        logic [LW+1:0]     ev;
        logic [LW+1:0]     av;
        int                seen;

        vt[0] = '{4096,   0,      1'b0, 1'b1};
        vt[1] = '{-8192,  4096,   1'b1, 1'b1};
        vt[2] = '{1,      -49152, 1'b0, 1'b1};
        vt[3] = '{-32768, 12288,  1'b1, 1'b1};
`ifdef LOG_ENC_CORR_EN
        vt[4] = '{6144,   2560,   1'b0, 1'b1};
        vt[7] = '{3,      -42496, 1'b0, 1'b1};
        vt[8] = '{5120,   1280,   1'b0, 1'b1};
`else
        vt[4] = '{6144,   2048,   1'b0, 1'b1};
        vt[7] = '{3,      -43008, 1'b0, 1'b1};
        vt[8] = '{5120,   1024,   1'b0, 1'b1};
`endif
        vt[5] = '{0,      0,      1'b0, 1'b0};
        vt[6] = '{-1,     -49152, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_log_bits",   $countones(log_out_packed),   0);
        chk("rst_sign_bits",  $countones(sign_out_packed),  0);
        chk("rst_vld_bits",   $countones(valid_out_packed), 0);
        chk("rst_out_valid",  out_valid, 0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Table vectors, one at a time, with latency check
        for (int i = 0; i < 9; i++) begin
            send(vt[i].din[WIDTH-1:0]);
            chk("lat_no_early_valid", out_valid, 0);
            @(posedge clk);
            #1;
            chk("vec_out_valid", out_valid, 1);
            chk("vec_log",  int'($signed(log_out_packed[LW-1:0])), vt[i].exp_log);
            chk("vec_sign", sign_out_packed[0],  vt[i].exp_sign);
            chk("vec_vld",  valid_out_packed[0], vt[i].exp_vld);
        end
        @(posedge clk);
        #1;

        // Backpressure: streaming input, consumer stalls 5 cycles
        fork
            begin
                for (int i = 0; i < 12; i++) send(WIDTH'(100 + i * 37));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                snap = log_out_packed;
                repeat (5) @(posedge clk);
                #1;
                chk("bp_in_ready_low",   in_ready, 0);
                chk("bp_out_valid_held", out_valid, 1);
                chk("bp_taps_frozen",    $countones(log_out_packed ^ snap), 0);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_sb_drained", sb_q.size(), 0);

        // ORD+3 samples: tap k holds sample ORD+3-k
        for (int i = 1; i <= ORD + 3; i++) send(WIDTH'(i));
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < ORD; k++) begin
            ev = enc(ORD + 3 - k);
            av = {log_out_packed[LW*k +: LW], sign_out_packed[k], valid_out_packed[k]};
            chk("fill_tap", av, ev);
        end

        // Clear with a simultaneous offered sample
        clear    = 1'b1;
        in_data  = WIDTH'(5);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_log_bits",  $countones(log_out_packed),   0);
        chk("clr_sign_bits", $countones(sign_out_packed),  0);
        chk("clr_vld_bits",  $countones(valid_out_packed), 0);
        chk("clr_out_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("clr_accept_dropped", $countones(valid_out_packed) + int'(out_valid), 0);
        chk("clr_sb_empty", sb_q.size(), 0);

        // Reset one cycle after an accept
        send(WIDTH'(1000));
        send(WIDTH'(-2000));
        send(WIDTH'(300));
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_sb_empty", sb_q.size(), 0);
        send(WIDTH'(777));
        reset = 1'b0;
        #1;
        sb_q.delete();
        chk("mid_rst_log_bits",  $countones(log_out_packed),   0);
        chk("mid_rst_sign_bits", $countones(sign_out_packed),  0);
        chk("mid_rst_vld_bits",  $countones(valid_out_packed), 0);
        chk("mid_rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid || (valid_out_packed != '0)) seen = 1;
        end
        chk("rst_inflight_discarded", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
